// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: one-hot FSM state
// encodings and the bit position of each physical button on the 5-bit buses.
package btn_pkg;

    // One-hot debounce FSM states; a corrupted (non one-hot) value is steered
    // back to ST_IDLE by the FSM's default branch.
    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_WQ   = 5'b00010,
        ST_SCEN = 5'b00100,
        ST_HELD = 5'b01000,
        ST_WR   = 5'b10000
    } btn_state_e;

    // Number of button channels and their bit indices on Btn_* buses.
    localparam int unsigned N_BTN = 5;
    localparam int unsigned BTN_L = 4;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_U = 2;
    localparam int unsigned BTN_D = 1;
    localparam int unsigned BTN_C = 0;

    // Debounced level is high whenever the button is considered pressed,
    // including while the release is still being qualified.
    function automatic logic state_is_pressed(input btn_state_e st);
        logic pressed;
        case (st)
            ST_SCEN: pressed = 1'b1;
            ST_HELD: pressed = 1'b1;
            ST_WR:   pressed = 1'b1;
            default: pressed = 1'b0;
        endcase
        return pressed;
    endfunction

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, stability counter and a
// 5-state debounce FSM producing a debounced level and a one-cycle press pulse.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned N_DC = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_raw_i,
    output logic btn_dpb_o,
    output logic btn_scen_o
);

    localparam logic [N_DC-1:0] CNT_MAX  = {N_DC{1'b1}};
    localparam logic [N_DC-1:0] CNT_ZERO = {N_DC{1'b0}};
    localparam logic [N_DC-1:0] CNT_ONE  = {{(N_DC-1){1'b0}}, 1'b1};

    logic            sync1_q;
    logic            sync2_q;
    btn_state_e      state_q;
    btn_state_e      state_d;
    logic [N_DC-1:0] cnt_q;
    logic [N_DC-1:0] cnt_d;
    logic            dpb_q;
    logic            scen_q;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered Moore outputs (decoded from next state so
    // they line up with the state register).
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            dpb_q   <= 1'b0;
            scen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dpb_q   <= state_is_pressed(state_d);
            scen_q  <= (state_d == ST_SCEN);
        end
    end

    // Next-state and counter logic; the counter saturates at all-ones because
    // reaching it always leaves the counting state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_WQ;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WQ: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_SCEN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SCEN: begin
                state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!sync2_q) begin
                    state_d = ST_WR;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_HELD;
                end
            end
            ST_WR: begin
                if (sync2_q) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign btn_dpb_o  = dpb_q;
    assign btn_scen_o = scen_q;

endmodule : btn_debounce_ch

// File: rtl/button_conditioner.sv
// Five independent debounced push-button channels plus an any-press pulse.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_DC = 20
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] Btn_raw,
    output logic [N_BTN-1:0] Btn_dpb,
    output logic [N_BTN-1:0] Btn_scen,
    output logic             Any_scen
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .N_DC (N_DC)
        ) u_ch (
            .Clk        (Clk),
            .Reset      (Reset),
            .btn_raw_i  (Btn_raw[i]),
            .btn_dpb_o  (Btn_dpb[i]),
            .btn_scen_o (Btn_scen[i])
        );
    end

    assign Any_scen = |Btn_scen;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with a 16-cycle window.
// Each loop iteration c drives Btn_raw/Reset before rising edge c and checks
// outputs 1 time unit after that edge; a press first sampled at edge E yields
// its pulse at c = E + 18.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int unsigned N_DC = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [4:0] Btn_raw = 5'b00000;
    logic [4:0] Btn_dpb;
    logic [4:0] Btn_scen;
    logic       Any_scen;

    int n_checks = 0;
    int n_fail = 0;

    button_conditioner #(.N_DC(N_DC)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Btn_raw  (Btn_raw),
        .Btn_dpb  (Btn_dpb),
        .Btn_scen (Btn_scen),
        .Any_scen (Any_scen)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        Btn_raw = 5'b00000;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b0;
        Btn_raw = 5'b11111;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk); #1;
            n_checks++;
            if ({Btn_dpb, Btn_scen, Any_scen} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset c=%0d: dpb=%b scen=%b any=%b, required all 0", c, Btn_dpb, Btn_scen, Any_scen);
            end
            @(negedge Clk);
        end
        Btn_raw = 5'b00000;
        Reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk); #1;
            n_checks++;
            if ({Btn_dpb, Btn_scen, Any_scen} !== 11'd0) begin
                n_fail++;
                $display("FAIL idle c=%0d: dpb=%b scen=%b any=%b, required all 0", c, Btn_dpb, Btn_scen, Any_scen);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] es;
        logic [4:0] ed;
        do_reset();
        for (int c = 0; c < 76; c++) begin
            @(negedge Clk);
            Btn_raw = 5'b00000;
            Btn_raw[BTN_U] = (c >= 10 && c < 50);
            @(posedge Clk); #1;
            es = (c == 28) ? 5'b00100 : 5'b00000;
            ed = (c >= 28 && c < 68) ? 5'b00100 : 5'b00000;
            n_checks += 3;
            if (Btn_scen !== es) begin n_fail++; $display("FAIL clean_scen c=%0d: got %b need %b", c, Btn_scen, es); end
            if (Btn_dpb !== ed) begin n_fail++; $display("FAIL clean_dpb c=%0d: got %b need %b", c, Btn_dpb, ed); end
            if (Any_scen !== (c == 28)) begin n_fail++; $display("FAIL clean_any c=%0d: got %b", c, Any_scen); end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] es;
        logic [4:0] ed;
        logic       r;
        do_reset();
        for (int c = 0; c < 42; c++) begin
            r = (c < 3) || (c >= 6 && c < 9) || (c >= 12);
            @(negedge Clk);
            Btn_raw = 5'b00000;
            Btn_raw[BTN_D] = r;
            @(posedge Clk); #1;
            es = (c == 30) ? 5'b00010 : 5'b00000;
            ed = (c >= 30) ? 5'b00010 : 5'b00000;
            n_checks += 2;
            if (Btn_scen !== es) begin n_fail++; $display("FAIL bounce_scen c=%0d: got %b need %b", c, Btn_scen, es); end
            if (Btn_dpb !== ed) begin n_fail++; $display("FAIL bounce_dpb c=%0d: got %b need %b", c, Btn_dpb, ed); end
        end
    endtask

    task automatic test_release_bounce();
        logic [4:0] es;
        logic [4:0] ed;
        logic       r;
        do_reset();
        for (int c = 0; c < 76; c++) begin
            r = (c < 30) || (c >= 35 && c < 40) || (c >= 45 && c < 50);
            @(negedge Clk);
            Btn_raw = 5'b00000;
            Btn_raw[BTN_L] = r;
            @(posedge Clk); #1;
            es = (c == 18) ? 5'b10000 : 5'b00000;
            ed = (c >= 18 && c < 68) ? 5'b10000 : 5'b00000;
            n_checks += 2;
            if (Btn_scen !== es) begin n_fail++; $display("FAIL relbounce_scen c=%0d: got %b need %b", c, Btn_scen, es); end
            if (Btn_dpb !== ed) begin n_fail++; $display("FAIL relbounce_dpb c=%0d: got %b need %b", c, Btn_dpb, ed); end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] es;
        logic [4:0] ed;
        do_reset();
        for (int c = 0; c < 52; c++) begin
            @(negedge Clk);
            Btn_raw = (c < 30) ? 5'b10001 : 5'b00000;
            @(posedge Clk); #1;
            es = (c == 18) ? 5'b10001 : 5'b00000;
            ed = (c >= 18 && c < 48) ? 5'b10001 : 5'b00000;
            n_checks += 3;
            if (Btn_scen !== es) begin n_fail++; $display("FAIL simul_scen c=%0d: got %b need %b", c, Btn_scen, es); end
            if (Btn_dpb !== ed) begin n_fail++; $display("FAIL simul_dpb c=%0d: got %b need %b", c, Btn_dpb, ed); end
            if (Any_scen !== (c == 18)) begin n_fail++; $display("FAIL simul_any c=%0d: got %b", c, Any_scen); end
        end
    endtask

    task automatic test_reset_mid_wq();
        logic [4:0] es;
        logic [4:0] ed;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            Btn_raw = 5'b00001;
            Reset = !(c == 12 || c == 13);
            @(posedge Clk); #1;
            es = (c == 32) ? 5'b00001 : 5'b00000;
            ed = (c >= 32) ? 5'b00001 : 5'b00000;
            n_checks += 3;
            if (Btn_scen !== es) begin n_fail++; $display("FAIL rstwq_scen c=%0d: got %b need %b", c, Btn_scen, es); end
            if (Btn_dpb !== ed) begin n_fail++; $display("FAIL rstwq_dpb c=%0d: got %b need %b", c, Btn_dpb, ed); end
            if (Any_scen !== (c == 32)) begin n_fail++; $display("FAIL rstwq_any c=%0d: got %b", c, Any_scen); end
        end
    endtask

    task automatic test_reset_mid_held();
        logic [4:0] es;
        logic [4:0] ed;
        do_reset();
        for (int c = 0; c < 56; c++) begin
            @(negedge Clk);
            Btn_raw = 5'b00100;
            Reset = !(c == 25 || c == 26);
            @(posedge Clk); #1;
            es = (c == 18 || c == 45) ? 5'b00100 : 5'b00000;
            ed = ((c >= 18 && c < 25) || c >= 45) ? 5'b00100 : 5'b00000;
            n_checks += 2;
            if (Btn_scen !== es) begin n_fail++; $display("FAIL rstheld_scen c=%0d: got %b need %b", c, Btn_scen, es); end
            if (Btn_dpb !== ed) begin n_fail++; $display("FAIL rstheld_dpb c=%0d: got %b need %b", c, Btn_dpb, ed); end
        end
    endtask

    task automatic test_long_hold();
        logic [4:0] es;
        logic [4:0] ed;
        int         pulses;
        pulses = 0;
        do_reset();
        for (int c = 0; c < 530; c++) begin
            @(negedge Clk);
            Btn_raw = (c < 500) ? 5'b01000 : 5'b00000;
            @(posedge Clk); #1;
            if (Btn_scen[BTN_R]) pulses++;
            es = (c == 18) ? 5'b01000 : 5'b00000;
            ed = (c >= 18 && c < 518) ? 5'b01000 : 5'b00000;
            n_checks += 2;
            if (Btn_scen !== es) begin n_fail++; $display("FAIL hold_scen c=%0d: got %b need %b", c, Btn_scen, es); end
            if (Btn_dpb !== ed) begin n_fail++; $display("FAIL hold_dpb c=%0d: got %b need %b", c, Btn_dpb, ed); end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL hold_pulse_count: got %0d need 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid_wq();
        test_reset_mid_held();
        test_long_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_conditioner

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: N_DC, default 20, width of the per-channel debounce counter; the stability window is 2^N_DC cycles (about 10.5 ms at 100 MHz).
REQ-002 Port: Clk  input  1  system clock; all logic is on the rising edge.
REQ-003 Port: Reset  input  1  reset, synchronous and active-low.
REQ-004 Port: Btn_raw  input  5  raw asynchronous push-buttons, mapped {Lbtn,Rbtn,Ubtn,Dbtn,Cbtn} = bits [4:0], active-high.
REQ-005 Port: Btn_dpb  output  5  debounced level per channel, same bit mapping.
REQ-006 Port: Btn_scen  output  5  single-clock-enable pulse per channel; this is what feeds the game FSM's Lbtn/Rbtn/Ubtn/Dbtn/Cbtn.
REQ-007 Port: Any_scen  output  1  OR of Btn_scen[4:0].

Function
REQ-010 Each channel SHALL pass its raw bit through a 2-flip-flop synchronizer; the second stage is the signal S.
REQ-011 Each channel SHALL run an independent 5-state FSM: IDLE, WQ (wait press stable), SCEN, HELD, WR (wait release stable).
REQ-012 IDLE: if S=1, go to WQ with counter cleared to 0; otherwise stay in IDLE.
REQ-013 WQ: if S=0, go to IDLE (bounce rejected); else if counter = 2^N_DC-1, go to SCEN; else increment the counter.
REQ-014 SCEN: stay for exactly one cycle, then go unconditionally to HELD.
REQ-015 HELD: if S=0, go to WR with counter cleared; otherwise stay in HELD, with no further pulses while the button is held.
REQ-016 WR: if S=1, go back to HELD; else if counter = 2^N_DC-1, go to IDLE; else increment the counter.
REQ-017 Outputs are Moore outputs: Btn_scen[i]=1 only in SCEN; Btn_dpb[i]=1 in SCEN, HELD and WR.
REQ-018 Press latency: a stable press first sampled by the synchronizer at edge E puts SCEN in the cycle after edge E+2^N_DC+2.
REQ-019 Release latency: Btn_dpb falls at edge E+2^N_DC+2 after a stable release is first sampled at edge E.
REQ-020 The counter SHALL be N_DC bits, compared only against all-ones, and SHALL never wrap.
REQ-021 Channels are fully independent; simultaneous presses SHALL produce simultaneous pulses, with no priority or lockout.
REQ-022 Exactly one Btn_scen pulse per debounced press, regardless of hold length.

Reset
REQ-030 When Reset=0 at a rising edge, all synchronizer flops, FSMs (to IDLE) and counters (to 0) SHALL clear; all outputs read 0 in the following cycle.
REQ-031 Reset asserted mid-operation (any state) SHALL abort that state with no pulse emitted.
REQ-032 A button held through reset release SHALL produce one Btn_scen after the full REQ-018 latency.

Structure
REQ-040 Package btn_pkg SHALL hold the state encodings (one-hot, 5 bits) and the channel bit-index constants L=4, R=3, U=2, D=1, C=0.
REQ-041 Sub-module btn_debounce_ch (synchronizer + FSM + counter, parameter N_DC) SHALL be instantiated 5 times; the top holds only the instances and the Any_scen OR.

Verification (N_DC=4, window 16 cycles)
REQ-050 Clean press: raw 0->1 sampled at edge 10, held for 40 cycles -> Btn_scen[2] high only in the cycle after edge 28, and Btn_dpb[2] rises at that same edge.
REQ-051 Bounce: raw toggles every 3 cycles for 12 cycles, then stays high -> exactly one pulse, 18 edges after the last rising sample; no earlier pulse.
REQ-052 Release bounce: from HELD, raw toggles 1/0 every 5 cycles, then stays low -> Btn_dpb stays 1 through the toggling, falls 18 edges after the last low sample, and no Btn_scen occurs.
REQ-053 Simultaneous: bits 4 and 0 pressed on the same edge -> Btn_scen[4] and Btn_scen[0] pulse in the same cycle, and Any_scen=1 for exactly that cycle.
REQ-054 Reset mid-WQ: Reset=0 at counter=9 -> no pulse; with raw still high after release, one pulse 18 edges after the first post-reset sample.
REQ-055 Long hold: raw high for 500 cycles -> exactly one Btn_scen pulse, and Btn_dpb=1 throughout the hold after the debounce window.
